pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Issue-side hazard controller for the 5-stage pipeline.
- Keeps a per-register scoreboard of in-flight writes, grants or stalls each decode issue, and holds fetch while a control-flow instruction is unresolved.
- Drives the FetchStall/DepStall signals that Decode forwards through Execute/Memory/Writeback, so downstream stages see only granted instructions.

Parameters:
NUM_REGS, 16, number of architectural registers tracked
IDX_WIDTH, 4, register index width (log2 NUM_REGS)
CNT_WIDTH, 2, per-register pending-write counter width; max in-flight writes per register = 2^CNT_WIDTH-1

Ports:
I_CLOCK  in  1  pipeline clock; all state updates on negedge, matching the other pipeline stages
I_RESET  in  1  synchronous, active-high reset, sampled on the negedge of I_CLOCK
I_IssueValid  in  1  Decode presents an instruction this cycle
I_IssueSrc1Idx  in  IDX_WIDTH  source 1 register
I_IssueSrc1Used  in  1  source 1 is read
I_IssueSrc2Idx  in  IDX_WIDTH  source 2 register
I_IssueSrc2Used  in  1  source 2 is read
I_IssueDestIdx  in  IDX_WIDTH  destination register
I_IssueDestWr  in  1  instruction writes a register
I_IssueIsBranch  in  1  instruction is BR*/JMP/JSR/JSRR
I_WBValid  in  1  Writeback retires a register write this cycle
I_WBDestIdx  in  IDX_WIDTH  register being retired
I_BrResolve  in  1  branch target/outcome resolved downstream
O_IssueGrant  out  1  instruction accepted this cycle (combinational)
O_DepStall  out  1  issue blocked by data hazard (combinational)
O_FetchStall  out  1  fetch held pending branch resolution (registered)
O_BusyMask  out  NUM_REGS  bit i = register i has a nonzero pending counter (registered)
O_Error  out  1  sticky: retire of a register with pending count 0

Behaviour:
Reset (I_RESET=1 at a negedge):
- All counters cleared; state=RUN; O_FetchStall=0, O_BusyMask=0, O_Error=0.
- While I_RESET is high, O_IssueGrant=0 and O_DepStall=0 regardless of other inputs.
- Reset mid-BR_WAIT returns to RUN and discards any pending branch.

FSM:
- RUN: issue allowed.
- RUN -> BR_WAIT at the negedge where a grant has I_IssueIsBranch=1.
- BR_WAIT: O_FetchStall=1, O_IssueGrant=0, O_DepStall=0.
- BR_WAIT -> RUN at the first negedge sampling I_BrResolve=1. O_FetchStall falls with the transition.
- I_BrResolve in RUN is ignored.

Grant (combinational, RUN only):
- src_busy(s) = Used(s) and cnt[Idx(s)] != 0.
- dest_full = I_IssueDestWr and cnt[DestIdx] == max.
- O_IssueGrant = I_IssueValid and not src_busy(1) and not src_busy(2) and not dest_full.
- O_DepStall = I_IssueValid and RUN and not O_IssueGrant.
- Grant decision has zero-cycle latency. The scoreboard update is visible from the next cycle.

Counter update per negedge, for each register r:
- inc = grant and I_IssueDestWr and DestIdx==r.
- dec = I_WBValid and WBDestIdx==r.
- inc and dec on the same register in the same cycle: counter unchanged.
- dec with cnt==0: counter stays 0 and O_Error sets. O_Error clears only on reset.
- Counters never wrap, because dest_full blocks issue at the max value.
- O_BusyMask is updated from the new counter values at the same edge.

Other rules:
- A write-after-write to the same destination is allowed up to the max count; only reads stall.
- A branch that also writes (JSR/JSRR) both increments its destination and enters BR_WAIT.

Optional Feature:
Macro: WB_BYPASS_EN.
- Defined: a source whose counter equals 1 and which is retired in the same cycle (I_WBValid, WBDestIdx==Idx) is treated as not busy, so the grant occurs in the retire cycle.
- Undefined: the source stays busy for that cycle, and the grant occurs one cycle later.

Test Plan:
- Reset, then issue ADD r3 (DestWr); next cycle issue reads r3 -> cycle 1 grant=1, O_BusyMask=0x0008; cycle 2 O_DepStall=1, grant=0.
- Retire r3 (I_WBValid, idx 3) while a reader of r3 waits -> without WB_BYPASS_EN the grant comes the cycle after retire; with WB_BYPASS_EN the grant comes in the retire cycle; BusyMask bit 3 clears at that edge.
- Issue 3 writes to r5 with no retire, then a 4th write to r5 -> first three granted, 4th O_DepStall=1; counter holds at 3.
- Issue BRZ -> O_FetchStall=1 from next cycle; a held I_IssueValid gets grant=0 and O_DepStall=0; pulse I_BrResolve -> O_FetchStall=0 next cycle and issue resumes.
- Same-cycle issue write r7 and retire r7 with cnt[7]=1 -> cnt[7] stays 1 and BusyMask bit 7 stays set; retire r9 with cnt[9]=0 -> O_Error=1 and stays set until I_RESET.
- Assert I_RESET during BR_WAIT with several counters nonzero -> next cycle state=RUN, O_FetchStall=0, O_BusyMask=0, O_Error=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Issue-side hazard controller: per-register pending-write scoreboard, issue grant/stall,
// and fetch hold while a branch is unresolved. Optional macro WB_BYPASS_EN: same-cycle retire bypass.
module pipeline_hazard_ctrl #(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned IDX_WIDTH = 4,
  parameter int unsigned CNT_WIDTH = 2
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESET,
  input  logic                 I_IssueValid,
  input  logic [IDX_WIDTH-1:0] I_IssueSrc1Idx,
  input  logic                 I_IssueSrc1Used,
  input  logic [IDX_WIDTH-1:0] I_IssueSrc2Idx,
  input  logic                 I_IssueSrc2Used,
  input  logic [IDX_WIDTH-1:0] I_IssueDestIdx,
  input  logic                 I_IssueDestWr,
  input  logic                 I_IssueIsBranch,
  input  logic                 I_WBValid,
  input  logic [IDX_WIDTH-1:0] I_WBDestIdx,
  input  logic                 I_BrResolve,
  output logic                 O_IssueGrant,
  output logic                 O_DepStall,
  output logic                 O_FetchStall,
  output logic [NUM_REGS-1:0]  O_BusyMask,
  output logic                 O_Error
);

  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  typedef enum logic [0:0] {StRun, StBrWait} state_e;

  state_e               state_q;
  logic                 fetch_stall_q;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic                 error_q, err_set;

  logic [CNT_WIDTH-1:0] cnt_src1, cnt_src2, cnt_dest;
  logic                 wb_hit1, wb_hit2;
  logic                 src1_busy, src2_busy, dest_full, run, grant;

  assign cnt_src1 = cnt_q[I_IssueSrc1Idx];
  assign cnt_src2 = cnt_q[I_IssueSrc2Idx];
  assign cnt_dest = cnt_q[I_IssueDestIdx];

`ifdef WB_BYPASS_EN
  // The last outstanding write retiring this cycle makes the source readable now.
  assign wb_hit1 = I_WBValid && (I_WBDestIdx == I_IssueSrc1Idx) && (cnt_src1 == CntOne);
  assign wb_hit2 = I_WBValid && (I_WBDestIdx == I_IssueSrc2Idx) && (cnt_src2 == CntOne);
`else
  assign wb_hit1 = 1'b0;
  assign wb_hit2 = 1'b0;
`endif

  assign src1_busy = I_IssueSrc1Used && (cnt_src1 != '0) && !wb_hit1;
  assign src2_busy = I_IssueSrc2Used && (cnt_src2 != '0) && !wb_hit2;
  assign dest_full = I_IssueDestWr && (cnt_dest == CntMax);
  assign run       = (state_q == StRun) && !I_RESET;
  assign grant     = I_IssueValid && run && !src1_busy && !src2_busy && !dest_full;

  assign O_IssueGrant = grant;
  assign O_DepStall   = I_IssueValid && run && !grant;
  assign O_FetchStall = fetch_stall_q;
  assign O_BusyMask   = busy_q;
  assign O_Error      = error_q;

  always_comb begin
    err_set = 1'b0;
    busy_d  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      logic inc, dec;
      inc      = grant && I_IssueDestWr && (I_IssueDestIdx == IDX_WIDTH'(r));
      dec      = I_WBValid && (I_WBDestIdx == IDX_WIDTH'(r));
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CntOne;
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0) begin
          err_set = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CntOne;
        end
      end
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q        <= '0;
      error_q       <= 1'b0;
      state_q       <= StRun;
      fetch_stall_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q  <= busy_d;
      error_q <= error_q | err_set;
      unique case (state_q)
        StRun: begin
          if (grant && I_IssueIsBranch) begin
            state_q       <= StBrWait;
            fetch_stall_q <= 1'b1;
          end
        end
        StBrWait: begin
          if (I_BrResolve) begin
            state_q       <= StRun;
            fetch_stall_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= StRun;
          fetch_stall_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
